// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, W RUN cycles per operation.
// Optional subtract mode is compiled in with `define SERIAL_SUB_EN.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_SUB_EN
    input  logic         sub,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]  opa_q;
    logic [W-1:0]  opb_q;
    logic [W-1:0]  sum_q;
    logic [W-1:0]  sum_sh;
    logic [W-1:0]  opb_ld;
    logic [CW-1:0] cnt_q;
    logic          carry_q;
    logic          carry_ld;
    logic          accept;
    logic          last_bit;
    logic          fa_s;
    logic          fa_co;

    assign accept   = start_valid & start_ready;
    assign last_bit = (cnt_q == CW'(W - 1));

    // the single full-adder cell
    assign fa_s  = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign fa_co = (opa_q[0] & opb_q[0]) |
                   (carry_q & (opa_q[0] ^ opb_q[0]));

`ifdef SERIAL_SUB_EN
    // a - b computed as a + ~b + 1
    assign opb_ld   = sub ? ~b : b;
    assign carry_ld = sub | cin;
`else
    assign opb_ld   = b;
    assign carry_ld = cin;
`endif

    always_comb begin
        sum_sh        = sum_q >> 1;
        sum_sh[W-1]   = fa_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == IDLE);
        res_valid   = (state_q == DONE);
        busy        = (state_q == RUN) || (state_q == DONE);
        sum         = sum_q;
        cout        = (state_q == DONE) & carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            opa_q   <= a;
            opb_q   <= opb_ld;
            carry_q <= carry_ld;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            opa_q   <= opa_q >> 1;
            opb_q   <= opb_q >> 1;
            sum_q   <= sum_sh;
            carry_q <= fa_co;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule
